// File: rtl/btn_pkg.sv
// Shared types and constants for the button conditioning front end.
// Holds the per-channel FSM state type and the channel index map.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HELD      = 2'd1,
    REPEATING = 2'd2
  } btn_state_t;

  localparam int BTN_START = 0;
  localparam int BTN_MIN   = 1;
  localparam int BTN_SEC   = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button bus: raw levels in, debounced levels and press strobes out.
// master drives btn_raw; slave (the conditioner) drives level/pulse.
interface btn_conditioner_if #(
  parameter int N_BTN = 3
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_pulse
  );
endinterface

// File: rtl/btn_channel.sv
// One button: 2-flop sync, counter debouncer, press/repeat FSM.
// Ports: i_clk, i_rst (async high), i_raw -> o_level, o_pulse.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 20_000_000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = max2(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [DW-1:0] r_db_cnt;
  btn_state_t    r_state;
  logic [RW-1:0] r_rpt_cnt;
  logic          r_pulse;

  btn_state_t    w_state_nxt;
  logic [RW-1:0] w_cnt_nxt;
  logic          w_pulse_nxt;
  logic          w_toggle;
  logic          w_rise;
  logic          w_fall;

  // Level flips on this edge when the disagreement run completes.
  assign w_toggle = (r_sync2 != r_level) && (r_db_cnt == DB_LAST);
  assign w_rise   = w_toggle && !r_level;
  assign w_fall   = w_toggle && r_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_level  <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_db_cnt <= '0;
      end else if (w_toggle) begin
        r_db_cnt <= '0;
        r_level  <= ~r_level;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_rpt_cnt <= '0;
      r_pulse   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rpt_cnt <= w_cnt_nxt;
      r_pulse   <= w_pulse_nxt;
    end
  end

  // Decisions use the level transition happening on this same edge,
  // so the press pulse lands on the first high cycle of o_level.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_rpt_cnt;
    w_pulse_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_rise) begin
          w_pulse_nxt = 1'b1;
          w_state_nxt = HELD;
        end
      end
      HELD: begin
        if (w_fall) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (!REPEAT_EN) begin
          w_cnt_nxt = '0;
        end else if (r_rpt_cnt == DLY_LAST) begin
          w_pulse_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = REPEATING;
        end else begin
          w_cnt_nxt = r_rpt_cnt + 1'b1;
        end
      end
      REPEATING: begin
        if (w_fall) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (r_rpt_cnt == PER_LAST) begin
          w_pulse_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_rpt_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions N_BTN raw buttons into debounced levels and press strobes.
// Ports: clk_100MHz, reset (async high), bus (slave: raw in, level/pulse out).
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int               N_BTN           = 3,
  parameter int               DEBOUNCE_CYCLES = 1_000_000,
  parameter int               REPEAT_DELAY    = 50_000_000,
  parameter int               REPEAT_PERIOD   = 20_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = 3'b110
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  btn_conditioner_if.slave  bus
);

  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_pulse;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[g])
    ) u_ch (
      .i_clk   (clk_100MHz),
      .i_rst   (reset),
      .i_raw   (bus.btn_raw[g]),
      .o_level (w_level[g]),
      .o_pulse (w_pulse[g])
    );
  end

  assign bus.btn_level = w_level;
  assign bus.btn_pulse = w_pulse;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: window-based reference model plus
// directed scenarios with literal edge expectations and random soak.
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int N   = 3;
  localparam int DB  = 4;
  localparam int DLY = 10;
  localparam int PER = 3;
  localparam logic [N-1:0] MASK = 3'b110;

  logic clk = 1'b0;
  logic rst = 1'b1;

  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (DLY),
    .REPEAT_PERIOD   (PER),
    .REPEAT_MASK     (MASK)
  ) dut (
    .clk_100MHz (clk),
    .reset      (rst),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  logic [N-1:0]  m_s1 = '0;
  logic [N-1:0]  m_s2 = '0;
  logic [N-1:0]  m_lvl = '0;
  logic [N-1:0]  m_pul = '0;
  logic [DB-1:0] m_hist [N];
  int            m_press [N];
  logic [N-1:0]  prev_pul = '0;
  logic [N-1:0]  prev_lvl = '0;

  int pq [N][$];
  int lq [N][$];

  // Reference: level flips once the last DB samples of the second
  // sync stage all disagree with it; pulses come from press time.
  initial begin : compare
    logic old;
    int d;
    for (int c = 0; c < N; c++) begin
      m_hist[c] = '0;
      m_press[c] = 0;
    end
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
        m_s1 = '0;
        m_s2 = '0;
        m_lvl = '0;
        m_pul = '0;
        for (int c = 0; c < N; c++) m_hist[c] = '0;
      end else begin
        for (int c = 0; c < N; c++) begin
          m_hist[c] = {m_hist[c][DB-2:0], m_s2[c]};
          old = m_lvl[c];
          if (m_hist[c] == {DB{~old}}) m_lvl[c] = ~old;
          m_pul[c] = 1'b0;
          if (!old && m_lvl[c]) begin
            m_pul[c] = 1'b1;
            m_press[c] = edge_n;
          end else if (old && m_lvl[c] && MASK[c]) begin
            d = edge_n - m_press[c];
            if (d == DLY || (d > DLY && (d - DLY) % PER == 0))
              m_pul[c] = 1'b1;
          end
        end
        m_s2 = m_s1;
        m_s1 = bus.btn_raw;
      end
      #1;
      checks++;
      if (bus.btn_level !== m_lvl) begin
        errors++;
        $display("FAIL level @edge %0d: got %b expected %b",
                 edge_n, bus.btn_level, m_lvl);
      end
      checks++;
      if (bus.btn_pulse !== m_pul) begin
        errors++;
        $display("FAIL pulse @edge %0d: got %b expected %b",
                 edge_n, bus.btn_pulse, m_pul);
      end
      checks++;
      if ((bus.btn_pulse & prev_pul) != '0) begin
        errors++;
        $display("FAIL pulse_back2back @edge %0d: got %b expected 000",
                 edge_n, bus.btn_pulse & prev_pul);
      end
      for (int c = 0; c < N; c++) begin
        if (bus.btn_pulse[c] === 1'b1) pq[c].push_back(edge_n);
        if (bus.btn_level[c] !== prev_lvl[c]) lq[c].push_back(edge_n);
      end
      prev_pul = bus.btn_pulse;
      prev_lvl = bus.btn_level;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr();
    for (int c = 0; c < N; c++) begin
      pq[c].delete();
      lq[c].delete();
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_raw(input logic [N-1:0] v, output int k);
    @(negedge clk);
    bus.btn_raw = v;
    k = edge_n + 1;
  endtask

  function automatic int qat(input int c, input int i, input bit lv);
    if (lv) return (lq[c].size() > i) ? lq[c][i] : -1;
    return (pq[c].size() > i) ? pq[c][i] : -1;
  endfunction

  initial begin : stim
    int k, k2, r, hit, f1, f2, same;
    int hold [N];
    logic [N-1:0] v;
    bus.btn_raw = '0;
    repeat (3) @(negedge clk);
    chk("reset_level", int'(bus.btn_level), 0);
    chk("reset_pulse", int'(bus.btn_pulse), 0);
    rst = 1'b0;
    cyc(5);

    // clean press, no repeat
    clr();
    set_raw(3'b001, k);
    cyc(40);
    set_raw(3'b000, k2);
    cyc(12);
    chk("s1_npulse", pq[BTN_START].size(), 1);
    chk("s1_pulse_t", qat(BTN_START, 0, 0), k + 5);
    chk("s1_rise_t", qat(BTN_START, 0, 1), k + 5);
    chk("s1_fall_t", qat(BTN_START, 1, 1), k2 + 5);

    // 3-cycle glitch
    clr();
    set_raw(3'b010, k);
    cyc(2);
    set_raw(3'b000, k2);
    cyc(12);
    chk("s2_nlevel", lq[BTN_MIN].size(), 0);
    chk("s2_npulse", pq[BTN_MIN].size(), 0);

    // auto-repeat
    clr();
    set_raw(3'b010, k);
    cyc(29);
    set_raw(3'b000, k2);
    cyc(12);
    chk("s3_rel_t", k2 - k, 30);
    chk("s3_npulse", pq[BTN_MIN].size(), 8);
    chk("s3_p0", qat(BTN_MIN, 0, 0), k + 5);
    chk("s3_p1", qat(BTN_MIN, 1, 0), k + 15);
    chk("s3_p2", qat(BTN_MIN, 2, 0), k + 18);
    chk("s3_plast", qat(BTN_MIN, 7, 0), k + 33);
    chk("s3_fall_t", qat(BTN_MIN, 1, 1), k + 35);

    // bounce
    clr();
    for (int i = 0; i < 3; i++) begin
      set_raw(3'b100, k);
      cyc(1);
      set_raw(3'b000, k);
      cyc(1);
    end
    set_raw(3'b100, k);
    cyc(20);
    set_raw(3'b000, k2);
    cyc(12);
    chk("s4_rise_t", qat(BTN_SEC, 0, 1), k + 5);
    chk("s4_pulse_t", qat(BTN_SEC, 0, 0), k + 5);

    // reset mid-repeat
    clr();
    set_raw(3'b010, k);
    cyc(24);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("s5_async_level", int'(bus.btn_level), 0);
    chk("s5_async_pulse", int'(bus.btn_pulse), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r = edge_n;
    cyc(25);
    f1 = -1;
    f2 = -1;
    hit = 0;
    foreach (pq[BTN_MIN][i]) begin
      if (pq[BTN_MIN][i] > r) begin
        if (hit == 0) f1 = pq[BTN_MIN][i];
        if (hit == 1) f2 = pq[BTN_MIN][i];
        hit++;
      end
    end
    chk("s5_press_t", f1, r + 6);
    chk("s5_rpt_t", f2, r + 16);
    set_raw(3'b000, k2);
    cyc(12);

    // simultaneous presses
    clr();
    set_raw(3'b110, k);
    cyc(24);
    set_raw(3'b000, k2);
    cyc(12);
    chk("s6_ch0_npulse", pq[BTN_START].size(), 0);
    chk("s6_ch1_p0", qat(BTN_MIN, 0, 0), k + 5);
    chk("s6_n_eq", pq[BTN_SEC].size(), pq[BTN_MIN].size());
    same = 1;
    foreach (pq[BTN_MIN][i])
      if (qat(BTN_SEC, i, 0) != pq[BTN_MIN][i]) same = 0;
    chk("s6_trains_eq", same, 1);

    // random soak
    v = '0;
    for (int c = 0; c < N; c++) hold[c] = 1;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          v[c] = ~v[c];
          hold[c] = ($urandom_range(0, 3) == 0) ?
                    int'($urandom_range(10, 40)) :
                    int'($urandom_range(1, 8));
        end
      end
      bus.btn_raw = v;
      if ($urandom_range(0, 599) == 0) rst = 1'b1;
      else if (rst && $urandom_range(0, 1) == 0) rst = 1'b0;
    end
    rst = 1'b0;
    bus.btn_raw = '0;
    cyc(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
